// File: rtl/ds1302_pkg.sv
// Shared constants, FSM encoding and frame helpers for the ds1302 transaction sequencer.
package ds1302_pkg;

    localparam int unsigned TIME_W  = 56;
    localparam int unsigned FRAME_W = 88;

    localparam logic [7:0] CMD_WP_W    = 8'h8E;
    localparam logic [7:0] CMD_BURST_W = 8'hBE;
    localparam logic [7:0] CMD_BURST_R = 8'hBF;
    localparam logic [7:0] WP_SET      = 8'h80;
    localparam logic [7:0] WP_CLR      = 8'h00;

    // Time word position inside a write frame: after the WP command, WP data and burst command.
    localparam int unsigned FRAME_TIME_LSB = 24;

    localparam logic [FRAME_W-1:0] RD_FRAME = {80'h0, CMD_BURST_R};

    typedef enum logic [2:0] {
        StPwrup,
        StWrReq,
        StWrWait,
        StRdReq,
        StRdWait,
        StGap,
        StIdle
    } state_e;

    function automatic logic [FRAME_W-1:0] wr_frame(input logic [TIME_W-1:0] t);
        logic [FRAME_W-1:0] f;
        f = {WP_SET, {TIME_W{1'b0}}, CMD_BURST_W, WP_CLR, CMD_WP_W};
        f[FRAME_TIME_LSB +: TIME_W] = t;
        return f;
    endfunction

endpackage

// File: rtl/ds1302_ctrl_if.sv
// Frame handshake between the sequencer (master) and ds1302_intf (slave).
interface ds1302_ctrl_if;
    import ds1302_pkg::*;

    logic               wr_vld;
    logic               wr;
    logic [FRAME_W-1:0] din;
    logic [TIME_W-1:0]  data;
    logic               opera_done;

    modport master (output wr_vld, wr, din, input data, opera_done);
    modport slave  (input wr_vld, wr, din, output data, opera_done);

endinterface

// File: rtl/ds1302_dly_cnt.sv
// Loadable down-counter that saturates at zero; expire_o is high while the count is zero.
module ds1302_dly_cnt #(
    parameter int unsigned      Width  = 32,
    parameter logic [Width-1:0] RstVal = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [Width-1:0] len_i,
    output logic             expire_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start_i) begin
            cnt_d = len_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= RstVal;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/ds1302_ctrl.sv
// Sequencer upstream of ds1302_intf: start-up clock set, periodic burst reads, queued set requests.
// Optional transaction watchdog with sticky err: define DS1302_CTRL_TIMEOUT_EN.
module ds1302_ctrl
    import ds1302_pkg::*;
#(
    parameter int unsigned       PWRUP_CYC   = 2_500_000,
    parameter int unsigned       POLL_CYC    = 5_000_000,
    parameter int unsigned       GAP_CYC     = 250,
    parameter int unsigned       TIMEOUT_CYC = 50_000,
    parameter logic [TIME_W-1:0] INIT_TIME   = 56'h24_01_01_01_00_00_00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_vld_i,
    input  logic [TIME_W-1:0] set_time_i,
    output logic [TIME_W-1:0] time_bcd_o,
    output logic              time_vld_o,
    output logic              busy_o,
    output logic              err_o,
    ds1302_ctrl_if.master     bus_if
);

`ifdef DS1302_CTRL_TIMEOUT_EN
    localparam bit TimeoutEn = 1'b1;
`else
    localparam bit TimeoutEn = 1'b0;
`endif

    state_e             state_q, state_d;
    logic               done_q, done_rise;
    logic               pending_q, pending_d;
    logic [TIME_W-1:0]  set_time_q, set_time_d, next_time;
    logic               wr_q, wr_d;
    logic [FRAME_W-1:0] din_q, din_d;
    logic [TIME_W-1:0]  time_bcd_q, time_bcd_d;
    logic               time_vld_q, time_vld_d;
    logic               err_q, err_d;
    logic [31:0]        wdog_q, wdog_d;
    logic               wdog_hit, in_wait;
    logic               wr_vld;
    logic               dly_start, dly_exp, poll_start, poll_exp;

    ds1302_dly_cnt #(
        .Width  (32),
        .RstVal (32'(PWRUP_CYC - 1))
    ) u_dly (
        .clk      (clk),
        .rst      (rst),
        .start_i  (dly_start),
        .len_i    (32'(GAP_CYC - 1)),
        .expire_o (dly_exp)
    );

    // Expiry is seen in IDLE one cycle before RD_REQ, hence the extra cycle taken off the load.
    ds1302_dly_cnt #(
        .Width  (32),
        .RstVal ('0)
    ) u_poll (
        .clk      (clk),
        .rst      (rst),
        .start_i  (poll_start),
        .len_i    (32'(POLL_CYC - 2)),
        .expire_o (poll_exp)
    );

    assign done_rise = bus_if.opera_done & ~done_q;
    assign in_wait   = (state_q == StWrWait) || (state_q == StRdWait);
    assign wdog_hit  = TimeoutEn && in_wait && (wdog_q == 32'(TIMEOUT_CYC - 1));
    assign wdog_d    = (TimeoutEn && in_wait) ? wdog_q + 32'd1 : '0;
    // A set request arriving in the very cycle a write is launched goes straight into that frame.
    assign next_time = set_vld_i ? set_time_i : set_time_q;

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        set_time_d = set_time_q;
        wr_d       = wr_q;
        din_d      = din_q;
        time_bcd_d = time_bcd_q;
        time_vld_d = 1'b0;
        err_d      = err_q;
        wr_vld     = 1'b0;
        busy_o     = 1'b0;
        dly_start  = 1'b0;
        poll_start = 1'b0;

        if (set_vld_i) begin
            pending_d  = 1'b1;
            set_time_d = set_time_i;
        end

        unique case (state_q)
            StPwrup: begin
                if (dly_exp) begin
                    state_d = StWrReq;
                    wr_d    = 1'b0;
                    din_d   = wr_frame(INIT_TIME);
                end
            end
            StWrReq: begin
                wr_vld  = 1'b1;
                busy_o  = 1'b1;
                state_d = StWrWait;
            end
            StWrWait: begin
                busy_o = 1'b1;
                if (done_rise) begin
                    state_d   = StGap;
                    dly_start = 1'b1;
                end else if (wdog_hit) begin
                    state_d   = StGap;
                    dly_start = 1'b1;
                    err_d     = 1'b1;
                    pending_d = 1'b1;
                    if (!set_vld_i) begin
                        set_time_d = din_q[FRAME_TIME_LSB +: TIME_W];
                    end
                end
            end
            StRdReq: begin
                wr_vld     = 1'b1;
                busy_o     = 1'b1;
                poll_start = 1'b1;
                state_d    = StRdWait;
            end
            StRdWait: begin
                busy_o = 1'b1;
                if (done_rise) begin
                    time_bcd_d = bus_if.data;
                    time_vld_d = 1'b1;
                    state_d    = StGap;
                    dly_start  = 1'b1;
                end else if (wdog_hit) begin
                    err_d     = 1'b1;
                    state_d   = StGap;
                    dly_start = 1'b1;
                end
            end
            StGap: begin
                if (!dly_exp) begin
                    busy_o = 1'b1;
                end else if (pending_q) begin
                    state_d   = StWrReq;
                    wr_d      = 1'b0;
                    din_d     = wr_frame(next_time);
                    pending_d = 1'b0;
                end else begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                if (pending_q) begin
                    state_d   = StWrReq;
                    wr_d      = 1'b0;
                    din_d     = wr_frame(next_time);
                    pending_d = 1'b0;
                end else if (poll_exp) begin
                    state_d = StRdReq;
                    wr_d    = 1'b1;
                    din_d   = RD_FRAME;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StPwrup;
            done_q     <= 1'b0;
            pending_q  <= 1'b0;
            set_time_q <= '0;
            wr_q       <= 1'b1;
            din_q      <= '0;
            time_bcd_q <= '0;
            time_vld_q <= 1'b0;
            err_q      <= 1'b0;
            wdog_q     <= '0;
        end else begin
            state_q    <= state_d;
            done_q     <= bus_if.opera_done;
            pending_q  <= pending_d;
            set_time_q <= set_time_d;
            wr_q       <= wr_d;
            din_q      <= din_d;
            time_bcd_q <= time_bcd_d;
            time_vld_q <= time_vld_d;
            err_q      <= err_d;
            wdog_q     <= wdog_d;
        end
    end

    assign bus_if.wr_vld = wr_vld;
    assign bus_if.wr     = wr_q;
    assign bus_if.din    = din_q;
    assign time_bcd_o    = time_bcd_q;
    assign time_vld_o    = time_vld_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_ds1302_ctrl.sv
// Bench for ds1302_ctrl with a behavioural ds1302_intf model and a frame/time scoreboard.
`timescale 1ns/1ps
module tb_ds1302_ctrl;

    localparam int unsigned PWRUP = 20;
    localparam int unsigned POLL  = 400;
    localparam int unsigned GAP   = 5;
    localparam int unsigned TMO   = 100;
    localparam int          LAT   = 12;
    localparam logic [55:0] INIT  = 56'h24_01_01_01_00_00_00;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        set_vld = 1'b0;
    logic [55:0] set_time = '0;
    logic [55:0] time_bcd;
    logic        time_vld, busy, err;

    ds1302_ctrl_if u_if ();

    ds1302_ctrl #(
        .PWRUP_CYC   (PWRUP),
        .POLL_CYC    (POLL),
        .GAP_CYC     (GAP),
        .TIMEOUT_CYC (TMO),
        .INIT_TIME   (INIT)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .set_vld_i  (set_vld),
        .set_time_i (set_time),
        .time_bcd_o (time_bcd),
        .time_vld_o (time_vld),
        .busy_o     (busy),
        .err_o      (err),
        .bus_if     (u_if)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check_eq(input string tag, input logic [95:0] act, input logic [95:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    function automatic logic [87:0] exp_wr(input logic [55:0] t);
        return {8'h80, t, 8'hBE, 8'h00, 8'h8E};
    endfunction

    logic [55:0] tq[$];
    logic [87:0] wq[$];

    int cyc;
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 1;
        else     cyc <= cyc + 1;
    end

    // ds1302_intf model: opera_done for two cycles, LAT cycles after wr_vld.
    logic [55:0] model_time;
    bit          no_wr_done = 1'b0;
    int          lat = 0;
    int          hold = 0;
    logic        m_rd = 1'b0;
    logic        m_done = 1'b0;
    logic [55:0] m_cap = '0;
    logic [55:0] m_data = '0;
    assign u_if.opera_done = m_done;
    assign u_if.data       = m_data;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            lat    <= 0;
            hold   <= 0;
            m_done <= 1'b0;
            m_data <= '0;
            tq.delete();
        end else begin
            if (u_if.wr_vld) begin
                lat   <= LAT;
                m_rd  <= u_if.wr;
                m_cap <= model_time;
                if (u_if.wr) tq.push_back(model_time);
            end else if (lat > 0) begin
                lat <= lat - 1;
                if (lat == 1 && (m_rd || !no_wr_done)) begin
                    m_done <= 1'b1;
                    hold   <= 2;
                    if (m_rd) m_data <= m_cap;
                end
            end
            if (hold > 0) begin
                hold <= hold - 1;
                if (hold == 1) m_done <= 1'b0;
            end
        end
    end

    // Output monitor, sampled on the falling edge.
    logic        busy_p = 1'b0, tv_p = 1'b0, wr_p = 1'b1;
    logic [87:0] din_p = '0;
    int n_wr = 0, n_rd = 0, n_tv = 0;
    int last_rd = 0, wr_cyc = 0, tv_at_wr = 0;
    bit wr_since_rd = 1'b0;

    always @(negedge clk) begin
        logic [87:0] ef;
        logic [55:0] et;
        bit          have;
        if (rst) begin
            busy_p  = 1'b0;
            tv_p    = 1'b0;
            last_rd = 0;
        end else begin
            if (busy_p && busy) check_eq("hold_stable", {u_if.wr, u_if.din}, {wr_p, din_p});
            if (u_if.wr_vld) begin
                check_eq("wrvld_not_busy", busy_p, 1'b0);
                if (!u_if.wr) begin
                    n_wr++;
                    wr_cyc      = cyc;
                    tv_at_wr    = n_tv;
                    wr_since_rd = 1'b1;
                    ef = (wq.size() != 0) ? wq.pop_front() : '0;
                    check_eq("wr_frame", u_if.din, ef);
                end else begin
                    n_rd++;
                    ef = {80'h0, 8'hBF};
                    check_eq("rd_frame", u_if.din, ef);
                    if (last_rd != 0 && !wr_since_rd) check_eq("rd_period", cyc - last_rd, POLL);
                    last_rd     = cyc;
                    wr_since_rd = 1'b0;
                end
            end
            if (time_vld) begin
                n_tv++;
                check_eq("tv_pulse", tv_p, 1'b0);
                have = (tq.size() != 0);
                check_eq("tv_expected", have, 1'b1);
                if (have) begin
                    et = tq.pop_front();
                    check_eq("time_bcd", time_bcd, et);
                end
            end
            busy_p = busy;
            tv_p   = time_vld;
            wr_p   = u_if.wr;
            din_p  = u_if.din;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic int cur_cnt(input int which);
        case (which)
            0:       return n_wr;
            1:       return n_rd;
            default: return n_tv;
        endcase
    endfunction

    task automatic wait_evt(input int which, input int target, input int budget, input string tag);
        int k = 0;
        while (cur_cnt(which) < target && k < budget) begin
            tick();
            k++;
        end
        check_eq(tag, cur_cnt(which), target);
    endtask

    task automatic pulse_set(input logic [55:0] t);
        set_vld  = 1'b1;
        set_time = t;
        tick();
        set_vld = 1'b0;
    endtask

    task automatic check_reset(input string pfx);
        check_eq({pfx, "_time_bcd"}, time_bcd, 56'h0);
        check_eq({pfx, "_time_vld"}, time_vld, 1'b0);
        check_eq({pfx, "_busy"}, busy, 1'b0);
        check_eq({pfx, "_err"}, err, 1'b0);
        check_eq({pfx, "_wr_vld"}, u_if.wr_vld, 1'b0);
        check_eq({pfx, "_wr"}, u_if.wr, 1'b1);
        check_eq({pfx, "_din"}, u_if.din, 88'h0);
    endtask

    localparam int EvWr = 0;
    localparam int EvRd = 1;
    localparam int EvTv = 2;

    initial begin
        int w0, r0, tv0, t0;
        model_time = 56'h24_01_01_01_12_34_56;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_reset("rst");

        // Start-up clock set
        wq.push_back(exp_wr(INIT));
        @(negedge clk);
        rst = 1'b0;
        wait_evt(EvWr, 1, 40, "t1_wr_seen");
        check_eq("t1_wr_cycle", wr_cyc, 21);
        check_eq("t1_busy", busy, 1'b1);

        // First read and poll period
        wait_evt(EvTv, 1, 60, "t2_tv_seen");
        check_eq("t2_time", time_bcd, 56'h24_01_01_01_12_34_56);
        check_eq("t2_one_read", n_rd, 1);
        model_time = 56'h24_01_01_01_12_35_10;
        wait_evt(EvRd, 2, 450, "t2_rd2_seen");

        // Set during RD_WAIT: read completes, then the write
        tick();
        wq.push_back(exp_wr(56'h25_02_03_04_05_06_07));
        pulse_set(56'h25_02_03_04_05_06_07);
        tv0 = n_tv;
        wait_evt(EvWr, 2, 100, "t3_wr_seen");
        check_eq("t3_read_first", tv_at_wr, tv0 + 1);

        // Two sets before service: only the last is written
        r0 = n_rd;
        model_time = 56'h25_02_03_04_05_07_00;
        wait_evt(EvRd, r0 + 1, 500, "t4_rd_seen");
        tick();
        pulse_set(56'h26_01_11_12_13_14_15);
        tick();
        wq.push_back(exp_wr(56'h27_05_09_28_23_59_58));
        pulse_set(56'h27_05_09_28_23_59_58);
        w0 = n_wr;
        wait_evt(EvWr, w0 + 1, 100, "t4_wr_seen");
        repeat (60) tick();
        check_eq("t4_one_write", n_wr, w0 + 1);

        // Reset in RD_WAIT
        r0 = n_rd;
        wait_evt(EvRd, r0 + 1, 500, "t5_rd_seen");
        tick();
        tick();
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check_reset("t5");
        repeat (2) @(negedge clk);
        wq.push_back(exp_wr(INIT));
        w0 = n_wr;
        rst = 1'b0;
        wait_evt(EvWr, w0 + 1, 40, "t5_wr_seen");
        check_eq("t5_wr_cycle", wr_cyc, 21);
        tv0 = n_tv;
        wait_evt(EvTv, tv0 + 1, 60, "t5_tv_seen");

`ifdef DS1302_CTRL_TIMEOUT_EN
        // Write never acknowledged: timeout, sticky err, retry of the same frame
        no_wr_done = 1'b1;
        wq.push_back(exp_wr(56'h28_03_04_05_06_07_08));
        wq.push_back(exp_wr(56'h28_03_04_05_06_07_08));
        w0 = n_wr;
        pulse_set(56'h28_03_04_05_06_07_08);
        wait_evt(EvWr, w0 + 1, 100, "t6_wr_seen");
        t0 = wr_cyc;
        while (cyc < t0 + 99) tick();
        check_eq("t6_err_early", err, 1'b0);
        tick();
        tick();
        check_eq("t6_err_set", err, 1'b1);
        no_wr_done = 1'b0;
        wait_evt(EvWr, w0 + 2, 40, "t6_retry_seen");
        check_eq("t6_retry_cycle", wr_cyc - t0, 106);
        tv0 = n_tv;
        wait_evt(EvTv, tv0 + 1, 100, "t6_tv_after");
        check_eq("t6_err_sticky", err, 1'b1);
`else
        // Write never acknowledged: no watchdog, the FSM waits forever
        no_wr_done = 1'b1;
        wq.push_back(exp_wr(56'h28_03_04_05_06_07_08));
        w0 = n_wr;
        pulse_set(56'h28_03_04_05_06_07_08);
        wait_evt(EvWr, w0 + 1, 100, "t6_wr_seen");
        r0 = n_rd;
        t0 = n_wr;
        repeat (200) tick();
        check_eq("t6_err_zero", err, 1'b0);
        check_eq("t6_busy_hold", busy, 1'b1);
        check_eq("t6_no_read", n_rd, r0);
        check_eq("t6_no_write", n_wr, t0);
        no_wr_done = 1'b0;
        rst = 1'b1;
        repeat (2) tick();
        check_reset("t6");
        rst = 1'b0;
`endif

        check_eq("wq_drained", wq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

endmodule
